// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store control unit: funct3 codes, dmem select codes, FSM states.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] RSEL_WORD  = 3'd0;
  localparam logic [2:0] RSEL_HALF  = 3'd1;
  localparam logic [2:0] RSEL_BYTE  = 3'd2;
  localparam logic [2:0] RSEL_UHALF = 3'd3;
  localparam logic [2:0] RSEL_UBYTE = 3'd4;

  localparam logic [1:0] WSEL_WORD = 2'd0;
  localparam logic [1:0] WSEL_HALF = 2'd1;
  localparam logic [1:0] WSEL_BYTE = 2'd2;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic        err;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  rsel;
    logic [1:0]  wsel;
  } req_t;

endpackage

// File: rtl/lsu_decode.sv
// Combinational request decode: funct3 -> dmem selects, address alignment and error flag.
// LSU_MISALIGN_CHECK_EN: misaligned word/half accesses are rejected instead of having low bits dropped.
module lsu_decode
  import lsu_pkg::*;
#(
  parameter int MEM_AW = 13
) (
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  output logic [2:0]  rsel,
  output logic [1:0]  wsel,
  output logic [31:0] aligned_addr,
  output logic        err
);

  logic illegal, half, word, oor, mis;

  always_comb begin
    rsel    = RSEL_WORD;
    wsel    = WSEL_WORD;
    illegal = 1'b0;
    half    = 1'b0;
    word    = 1'b0;
    case (funct3)
      F3_B:  begin rsel = RSEL_BYTE; wsel = WSEL_BYTE; end
      F3_H:  begin rsel = RSEL_HALF; wsel = WSEL_HALF; half = 1'b1; end
      F3_W:  begin rsel = RSEL_WORD; wsel = WSEL_WORD; word = 1'b1; end
      F3_BU: begin rsel = RSEL_UBYTE; illegal = we; end
      F3_HU: begin rsel = RSEL_UHALF; illegal = we; half = 1'b1; end
      default: illegal = 1'b1;
    endcase
  end

  assign oor = |(addr >> MEM_AW);

`ifdef LSU_MISALIGN_CHECK_EN
  assign mis          = (word && addr[1:0] != 2'b00) || (half && addr[0]);
  assign aligned_addr = addr;
`else
  // Without the check the access silently lands on the containing aligned unit.
  assign mis          = 1'b0;
  assign aligned_addr = {addr[31:2], word ? 2'b00 : {addr[1], addr[0] & ~half}};
`endif

  assign err = illegal || oor || mis;

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller in front of dmem: one outstanding request, error requests skip memory.
// Optional LSU_MISALIGN_CHECK_EN enables misalignment errors (see lsu_decode).
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_AW = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_dataw,
  input  logic [31:0] dmem_datar,
  output logic        dmem_wen,
  output logic [2:0]  dmem_rsel,
  output logic [1:0]  dmem_wsel
);

  state_t      state, next;
  req_t        lat;
  logic [2:0]  dec_rsel;
  logic [1:0]  dec_wsel;
  logic [31:0] dec_addr;
  logic        dec_err;
  logic        accept;

  lsu_decode #(.MEM_AW(MEM_AW)) u_dec (
    .we           (req_we),
    .funct3       (req_funct3),
    .addr         (req_addr),
    .rsel         (dec_rsel),
    .wsel         (dec_wsel),
    .aligned_addr (dec_addr),
    .err          (dec_err)
  );

  assign accept = req_valid && req_ready;

  always_comb begin
    next       = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) next = dec_err ? RESP : ACCESS;
      end
      ACCESS: next = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          req_ready = 1'b1;
          next      = req_valid ? (dec_err ? RESP : ACCESS) : IDLE;
        end
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      lat   <= '0;
    end else begin
      state <= next;
      if (accept) lat <= '{we: req_we, err: dec_err, addr: dec_addr, wdata: req_wdata,
                           rsel: dec_rsel, wsel: dec_wsel};
    end
  end

  // Reset gates the write strobe directly so a store caught in ACCESS never commits.
  assign dmem_wen   = (state == ACCESS) && lat.we && rst_n;
  assign dmem_addr  = lat.addr;
  assign dmem_dataw = lat.wdata;
  assign dmem_rsel  = lat.rsel;
  assign dmem_wsel  = lat.wsel;

  assign resp_err   = (state == RESP) && lat.err;
  assign resp_rdata = (state == RESP && !lat.we && !lat.err) ? dmem_datar : 32'h0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: dmem stand-in, cycle-by-cycle behavioural model check, directed + random stimulus.
module tb_lsu_ctrl;
  localparam int MEM_AW = 13;
  localparam int DEPTH  = 1 << MEM_AW;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b1;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, resp_valid, resp_err, dmem_wen;
  logic [31:0] resp_rdata, dmem_addr, dmem_dataw;
  logic [31:0] dmem_datar = 32'h0;
  logic [2:0]  dmem_rsel;
  logic [1:0]  dmem_wsel;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dmem_addr(dmem_addr), .dmem_dataw(dmem_dataw), .dmem_datar(dmem_datar),
    .dmem_wen(dmem_wen), .dmem_rsel(dmem_rsel), .dmem_wsel(dmem_wsel)
  );

  logic [7:0] mem [DEPTH];  // the memory the DUT drives
  logic [7:0] sh  [DEPTH];  // model's view of what memory must contain

  function automatic logic [7:0] byte_at(bit shadow, logic [31:0] a);
    logic [MEM_AW-1:0] i;
    i = a[MEM_AW-1:0];
    return shadow ? sh[i] : mem[i];
  endfunction

  function automatic logic [31:0] mem_word(bit shadow, logic [31:0] a);
    return {byte_at(shadow, a + 3), byte_at(shadow, a + 2), byte_at(shadow, a + 1), byte_at(shadow, a)};
  endfunction

  // dmem: registered read with extension, byte-lane write
  always @(posedge clk) begin
    logic [15:0] h;
    logic [7:0]  b;
    h = {byte_at(0, dmem_addr + 1), byte_at(0, dmem_addr)};
    b = byte_at(0, dmem_addr);
    case (dmem_rsel)
      3'd0: dmem_datar <= mem_word(0, dmem_addr);
      3'd1: dmem_datar <= {{16{h[15]}}, h};
      3'd2: dmem_datar <= {{24{b[7]}}, b};
      3'd3: dmem_datar <= {16'h0, h};
      default: dmem_datar <= {24'h0, b};
    endcase
    if (dmem_wen) begin
      mem[dmem_addr[MEM_AW-1:0]] <= dmem_dataw[7:0];
      if (dmem_wsel != 2'd2) mem[MEM_AW'(dmem_addr + 1)] <= dmem_dataw[15:8];
      if (dmem_wsel == 2'd0) begin
        mem[MEM_AW'(dmem_addr + 2)] <= dmem_dataw[23:16];
        mem[MEM_AW'(dmem_addr + 3)] <= dmem_dataw[31:24];
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- behavioural model ----
  function automatic bit m_error(bit we, logic [2:0] f3, logic [31:0] a);
    bit bad;
    bad = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5);
    bad = bad || (a >= 32'(DEPTH));
`ifdef LSU_MISALIGN_CHECK_EN
    if (!(we && f3 > 3'd2)) begin
      if (f3[1:0] == 2'd2 && a[1:0] != 2'd0) bad = 1;
      if (f3[1:0] == 2'd1 && a[0]) bad = 1;
    end
`endif
    return bad;
  endfunction

  function automatic logic [31:0] m_align(logic [2:0] f3, logic [31:0] a);
`ifdef LSU_MISALIGN_CHECK_EN
    return a;
`else
    if (f3[1:0] == 2'd2) return a & ~32'd3;
    if (f3[1:0] == 2'd1) return a & ~32'd1;
    return a;
`endif
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] f3, logic [31:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = byte_at(1, a);
    h = {byte_at(1, a + 1), byte_at(1, a)};
    case (f3)
      3'd0: return {{24{b[7]}}, b};
      3'd1: return {{16{h[15]}}, h};
      3'd2: return mem_word(1, a);
      3'd4: return {24'h0, b};
      default: return {16'h0, h};
    endcase
  endfunction

  function automatic logic [2:0] m_rsel(logic [2:0] f3);
    case (f3)
      3'd0: return 3'd2;
      3'd1: return 3'd1;
      3'd4: return 3'd4;
      3'd5: return 3'd3;
      default: return 3'd0;
    endcase
  endfunction

  bit          m_live = 0, m_we, m_err;
  int          m_age, m_lat;
  logic [2:0]  m_f3;
  logic [31:0] m_addr, m_wdata;

  initial begin
    bit ev, er, ew;
    @(posedge clk);
    forever begin
      @(negedge clk);
      ev = m_live && m_age >= m_lat;
      er = !m_live || (ev && resp_ready);
      ew = m_live && m_we && !m_err && m_age == 1 && rst_n;
      chk("req_ready", req_ready, er);
      chk("resp_valid", resp_valid, ev);
      chk("dmem_wen", dmem_wen, ew);
      if (ev) begin
        chk("resp_err", resp_err, m_err);
        chk("resp_rdata", resp_rdata, (m_err || m_we) ? 32'h0 : m_load(m_f3, m_align(m_f3, m_addr)));
      end
      if (m_live && !m_err) begin
        chk("dmem_addr", dmem_addr, m_align(m_f3, m_addr));
        if (m_we) begin
          chk("dmem_dataw", dmem_dataw, m_wdata);
          chk("dmem_wsel", dmem_wsel, 32'(2 - m_f3));
        end else chk("dmem_rsel", dmem_rsel, m_rsel(m_f3));
      end
      if (ew) begin
        logic [31:0] a;
        a = m_align(m_f3, m_addr);
        for (int k = 0; k < (1 << m_f3[1:0]); k++) sh[MEM_AW'(a + k)] = m_wdata[8*k +: 8];
      end
      if (!rst_n) m_live = 0;
      else begin
        if (ev && resp_ready) m_live = 0;
        else if (m_live) m_age++;
        if (er && req_valid) begin
          m_live = 1; m_age = 1;
          m_we = req_we; m_f3 = req_funct3; m_addr = req_addr; m_wdata = req_wdata;
          m_err = m_error(req_we, req_funct3, req_addr);
          m_lat = m_err ? 1 : 2;
        end
      end
    end
  end

  // ---- directed request helper: issue, wait accept, wait response ----
  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rdata, output logic err, output int lat, output logic [31:0] aseen);
    int n;
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin n++; @(negedge clk); end
    if (n >= 20) chk("accept_timeout", 1, 0);
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resp_valid && lat < 20);
    if (lat >= 20) chk("resp_timeout", 1, 0);
    rdata = resp_rdata; err = resp_err; aseen = dmem_addr;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd, as, w0;
    logic        er;
    int          lt;
    for (int i = 0; i < DEPTH; i++) begin mem[i] = 8'($urandom); sh[i] = mem[i]; end
    {mem[35], mem[34], mem[33], mem[32]} = 32'hAABB_CCDD;
    {sh[35], sh[34], sh[33], sh[32]}     = 32'hAABB_CCDD;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_dmem_wen", dmem_wen, 0);
    chk("rst_dmem_addr", dmem_addr, 0);
    chk("rst_dmem_dataw", dmem_dataw, 0);
    chk("rst_dmem_rsel", dmem_rsel, 0);
    chk("rst_dmem_wsel", dmem_wsel, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    do_req(1, 3'd2, 32'h10, 32'h8000_00F0, rd, er, lt, as);
    chk("sw_err", er, 0); chk("sw_lat", lt, 2); chk("sw_rdata", rd, 0);
    do_req(0, 3'd2, 32'h10, 32'h0, rd, er, lt, as);
    chk("lw_rdata", rd, 32'h8000_00F0); chk("lw_lat", lt, 2);
    do_req(0, 3'd0, 32'h13, 32'h0, rd, er, lt, as);
    chk("lb_rdata", rd, 32'hFFFF_FF80);
    do_req(0, 3'd4, 32'h13, 32'h0, rd, er, lt, as);
    chk("lbu_rdata", rd, 32'h0000_0080);
    do_req(1, 3'd1, 32'h22, 32'h0000_1234, rd, er, lt, as);
    do_req(0, 3'd2, 32'h20, 32'h0, rd, er, lt, as);
    chk("sh_lw_rdata", rd, 32'h1234_CCDD);
    do_req(0, 3'd2, 32'h11, 32'h0, rd, er, lt, as);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("mis_err", er, 1); chk("mis_lat", lt, 1); chk("mis_rdata", rd, 0);
`else
    chk("mis_err", er, 0); chk("mis_addr", as, 32'h10); chk("mis_rdata", rd, 32'h8000_00F0);
`endif
    do_req(0, 3'd3, 32'h10, 32'h0, rd, er, lt, as);
    chk("ill_err", er, 1); chk("ill_rdata", rd, 0); chk("ill_lat", lt, 1);
    do_req(0, 3'd2, 32'h4000, 32'h0, rd, er, lt, as);
    chk("oor_err", er, 1); chk("oor_rdata", rd, 0);

    // response stall
    resp_ready = 1'b0;
    do_req(0, 3'd2, 32'h20, 32'h0, rd, er, lt, as);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rdata", resp_rdata, 32'h1234_CCDD);
      chk("stall_req_ready", req_ready, 0);
      chk("stall_valid", resp_valid, 1);
    end
    @(posedge clk); #1 resp_ready = 1'b1;
    @(posedge clk); #1;

    // reset while a store sits in ACCESS
    w0 = mem_word(0, 32'h40);
    req_we = 1; req_funct3 = 3'd2; req_addr = 32'h40; req_wdata = ~w0; req_valid = 1'b1;
    @(negedge clk); chk("rst_sw_accept", req_ready, 1);
    @(posedge clk); #1 req_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk); chk("rst_sw_wen", dmem_wen, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_sw_idle", req_ready, 1);
    chk("rst_sw_no_resp", resp_valid, 0);
    chk("rst_sw_mem", mem_word(0, 32'h40), w0);
    @(posedge clk); #1;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      req_valid  = ($urandom % 3) != 0;
      req_we     = $urandom % 2;
      req_funct3 = 3'($urandom % 8);
      req_addr   = ($urandom % 16 == 0) ? $urandom : 32'($urandom_range(0, 255));
      req_wdata  = $urandom;
      resp_ready = ($urandom % 4) != 0;
      rst_n      = ($urandom % 150) != 0;
      @(posedge clk); #1;
    end
    req_valid = 1'b0; resp_ready = 1'b1; rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    for (int i = 0; i < 256; i++) chk("final_mem", 32'(mem[i]), 32'(sh[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store control unit sitting directly upstream of the data memory (`dmem`). It accepts one memory request at a time from the execute/memory pipeline stage through a valid/ready handshake. It decodes RISC-V funct3 into the `dmem` read/write select codes, sequences the registered `dmem` access, and returns the load data or store acknowledge through a second valid/ready handshake. Misaligned, illegal and out-of-range requests are detected and answered with an error response; these requests never touch memory.

## Interface
- `MEM_AW`, default 13: byte-address width backed by `dmem`. `req_addr[31:MEM_AW]` != 0 is out of range.
- `clk`  in  1  clock; all state changes on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `req_valid`  in  1  request present
- `req_ready`  out  1  request accepted on an edge where `req_valid && req_ready`
- `req_we`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RISC-V funct3: load 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, right-aligned
- `resp_valid`  out  1  response present
- `resp_ready`  in  1  response consumed on an edge where `resp_valid && resp_ready`
- `resp_rdata`  out  32  load result (already extended by `dmem`); 0 for stores and errors
- `resp_err`  out  1  request rejected; memory untouched
- `dmem_addr`  out  32  to `dmem` addr
- `dmem_dataw`  out  32  to `dmem` dataw
- `dmem_datar`  in  32  from `dmem` datar (registered inside `dmem`)
- `dmem_wen`  out  1  to `dmem` Wen
- `dmem_rsel`  out  3  0 word, 1 half, 2 byte, 3 uhalf, 4 ubyte
- `dmem_wsel`  out  2  0 word, 1 half, 2 byte

## Operation
- FSM states:
  - IDLE: `req_ready` = 1.
  - ACCESS: drive `dmem`.
  - RESP: `resp_valid` = 1, wait for `resp_ready`.
- `req_ready` = IDLE || (RESP && `resp_ready`). Back-to-back acceptance is allowed on the response-consume edge.
- Accept: latch `we`, `funct3`, `addr`, `wdata`, and the decoded error flag.
  - Error flag clear: next state ACCESS.
  - Error flag set: next state RESP directly.
- Error flag is set by any of the following:
  - Illegal funct3: load 011/110/111; store 011 and above.
  - Out of range.
  - Misaligned: see Configuration.
- ACCESS lasts exactly one cycle, then RESP.
  - `dmem_wen` = latched `we` && `rst_n`. It is 0 in every other state.
- `dmem_addr`, `dmem_rsel`, `dmem_wsel` and `dmem_dataw` are driven from the latch in both ACCESS and RESP.
  - `dmem` keeps re-reading the same location, so `dmem_datar` stays stable during a RESP stall.
  - In IDLE these outputs hold their last values.
- In RESP:
  - Load without error: `resp_rdata` = `dmem_datar`.
  - Store or error: `resp_rdata` = 0.
  - `resp_err` = latched error flag.
- Response consumed with no new request: IDLE. With a new request accepted on the same edge: ACCESS or RESP, depending on the new request's error flag.

## Timing
- Reset values: state IDLE, `req_ready` 1, `resp_valid` 0, `resp_err` 0, `resp_rdata` 0, `dmem_wen` 0, `dmem_addr` 0, `dmem_dataw` 0, `dmem_rsel` 0, `dmem_wsel` 0.
- Normal request accepted at edge N:
  - `dmem_wen` (store) is high in cycle N+1.
  - `resp_valid` rises after edge N+1, i.e. 2 cycles after accept.
- Error request: `resp_valid` rises after edge N, i.e. 1 cycle after accept; no `dmem_wen` pulse.
- Sustained throughput with `resp_ready` held at 1: one request per 2 cycles.
- `resp_*` outputs are held unchanged while `resp_valid && !resp_ready`.
- Reset mid-operation: any state returns to IDLE on the reset edge and in-flight requests are dropped. `dmem_wen` is combinationally gated by `rst_n`, so a store in ACCESS during reset does not commit.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined:
  - LW/SW with `addr[1:0]` != 0 sets the error flag.
  - LH/LHU/SH with `addr[0]` != 0 sets the error flag.
- `LSU_MISALIGN_CHECK_EN` undefined:
  - No misalignment error.
  - The low address bits are forced to 0 on `dmem_addr`: bits [1:0] for word accesses, bit [0] for halfword accesses.

## Structure
- Package `lsu_pkg`:
  - funct3 constants.
  - `dmem` RSel/WSel code constants.
  - FSM state enum (IDLE, ACCESS, RESP).
- Combinational sub-module `lsu_decode`: funct3/we/addr in; rsel, wsel, aligned address and error flag out.

## Test plan
- Memory preloaded: SW 0x8000_00F0 @0x10, then LW @0x10: store ack `resp_err` 0; load `resp_rdata` = 0x8000_00F0 two cycles after accept.
- LB @0x13 and LBU @0x13 on word 0x8000_00F0: `resp_rdata` = 0xFFFF_FF80 and 0x0000_0080 respectively.
- SH 0x1234 @0x22 into word 0xAABB_CCDD, then LW @0x20: 0x1234_CCDD.
- With `LSU_MISALIGN_CHECK_EN`, LW @0x11: `resp_err` 1 one cycle after accept, `dmem_wen` never asserted. Without the macro: `dmem_addr` = 0x10.
- Load funct3 011, and LW @0x0000_4000 with `MEM_AW`=13: both give `resp_err` 1 and `resp_rdata` 0.
- `resp_ready` held low 5 cycles during an LW response: `resp_rdata` stable and `req_ready` 0. Then assert `rst_n` low during the ACCESS cycle of an SW: state IDLE, target word unchanged.
